// File: rtl/tone_scheduler.sv
// -----------------------------------------------------------------------------
// tone_scheduler
//   Two-requester note player. A round-robin arbiter in IDLE accepts one note
//   (frequency divider + duration), the PLAY state toggles the speaker with a
//   half-period divider for the requested number of cycles, then a fixed silent
//   GAP follows and note_done pulses on the last GAP cycle.
//
// Ports
//   clk                  : clock, all state on the rising edge
//   reset                : asynchronous active-low reset, synchronous release
//   req_valid[1:0]       : note request from requester i
//   req_ready[1:0]       : requester i accepted this cycle (one-hot or zero)
//   req0/1_freq          : tone divider, 0 = rest
//   req0/1_ticks         : note duration in cycles, 0 is played as 1
//   pause                : freeze playback, speaker silent
//   abort                : drop the current note, block acceptance in IDLE
//   speaker / speaker_n  : tone output and its complement
//   busy                 : FSM not in IDLE
//   grant_id             : requester owning the current or last note
//   note_done            : one-cycle pulse on the last GAP cycle
// -----------------------------------------------------------------------------
module tone_scheduler #(
  parameter int FREQ_W     = 8,
  parameter int TICK_W     = 12,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [FREQ_W-1:0] req0_freq,
  input  logic [FREQ_W-1:0] req1_freq,
  input  logic [TICK_W-1:0] req0_ticks,
  input  logic [TICK_W-1:0] req1_ticks,
  input  logic              pause,
  input  logic              abort,
  output logic              speaker,
  output logic              speaker_n,
  output logic              busy,
  output logic              grant_id,
  output logic              note_done
);

  // Gap counter holds the remaining GAP cycles including the current one.
  localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t              r_state;
  logic [FREQ_W-1:0]   r_freq;
  logic [FREQ_W-1:0]   r_cnt;
  logic [TICK_W-1:0]   r_ticks;
  logic [GAP_W-1:0]    r_gap;
  logic                r_speaker;
  logic                r_grant;
  logic                r_note_done;

  logic [1:0]          w_ready;
  logic                w_accept;
  logic                w_sel;
  logic [FREQ_W-1:0]   w_new_freq;
  logic [TICK_W-1:0]   w_new_ticks;
  logic [TICK_W-1:0]   w_load_ticks;
  logic [FREQ_W-1:0]   w_half;

  // Round-robin arbiter: on contention the requester that did not own the last
  // note wins. Gated by reset so nothing is offered while reset is held.
  always_comb begin
    w_ready = 2'b00;
    if (reset && (r_state == ST_IDLE) && !abort) begin
      case (req_valid)
        2'b01:   w_ready = 2'b01;
        2'b10:   w_ready = 2'b10;
        2'b11:   w_ready = r_grant ? 2'b01 : 2'b10;
        default: w_ready = 2'b00;
      endcase
    end else begin
      w_ready = 2'b00;
    end
  end

  assign w_accept     = |(req_valid & w_ready);
  assign w_sel        = w_ready[1];
  assign w_new_freq   = w_sel ? req1_freq  : req0_freq;
  assign w_new_ticks  = w_sel ? req1_ticks : req0_ticks;
  // A zero duration still plays a single PLAY cycle.
  assign w_load_ticks = (w_new_ticks == {TICK_W{1'b0}}) ? TICK_W'(1) : w_new_ticks;
  assign w_half       = r_freq >> 1;

  // Playback FSM with registered speaker, grant and done outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_freq      <= {FREQ_W{1'b0}};
      r_cnt       <= {FREQ_W{1'b0}};
      r_ticks     <= {TICK_W{1'b0}};
      r_gap       <= {GAP_W{1'b0}};
      r_speaker   <= 1'b0;
      r_grant     <= 1'b1;
      r_note_done <= 1'b0;
    end else begin
      r_note_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_speaker <= 1'b0;
          if (w_accept) begin
            r_grant <= w_sel;
            r_freq  <= w_new_freq;
            r_cnt   <= w_new_freq;
            r_ticks <= w_load_ticks;
            r_state <= ST_PLAY;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_PLAY: begin
          if (abort) begin
            r_state   <= ST_IDLE;
            r_speaker <= 1'b0;
          end else if (pause) begin
            r_speaker <= 1'b0;
          end else if (r_ticks <= TICK_W'(1)) begin
            // Last PLAY cycle: silence and move into the gap.
            r_ticks     <= {TICK_W{1'b0}};
            r_state     <= ST_GAP;
            r_speaker   <= 1'b0;
            r_gap       <= GAP_W'(GAP_CYCLES);
            r_note_done <= (GAP_CYCLES == 1) ? 1'b1 : 1'b0;
          end else begin
            r_ticks <= r_ticks - TICK_W'(1);
            if (r_cnt != {FREQ_W{1'b0}}) begin
              r_cnt     <= r_cnt - FREQ_W'(1);
              r_speaker <= (r_cnt >= w_half);
            end else begin
              // freq=0 lands here every cycle, giving a silent rest.
              r_cnt     <= r_freq;
              r_speaker <= 1'b0;
            end
          end
        end
        ST_GAP: begin
          r_speaker <= 1'b0;
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (pause) begin
            r_state <= ST_GAP;
          end else if (r_gap <= GAP_W'(1)) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap <= r_gap - GAP_W'(1);
            // Pulse while the final gap cycle is being shown.
            r_note_done <= (r_gap == GAP_W'(2)) ? 1'b1 : 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_speaker <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = w_ready;
  assign speaker   = r_speaker;
  assign speaker_n = ~r_speaker;
  assign busy      = (r_state != ST_IDLE);
  assign grant_id  = r_grant;
  assign note_done = r_note_done;

endmodule
